exec_mem_unit: RTL
==================

Name: exec_mem_unit

Overview:
- Datapath responder at the far end of the control-unit interface.
- Consumes operand1/operand2/offset/opcode/sel1/sel3/w_r as driven by the CU every cycle.
- Performs the ALU operation and the data-memory access in a 2-stage pipeline, then returns result2 to the CU for write-back.
- Holds the 2^ADDR_BITS x DATA_WIDTH data memory.

Parameters:
DATA_WIDTH, 8, operand/result/memory word width
ADDR_BITS, 5, data-memory address width (32 words)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset (asserted when 0)
operand1  input  DATA_WIDTH  ALU operand A / load-store base
operand2  input  DATA_WIDTH  ALU operand B; store data
offset  input  DATA_WIDTH  immediate / address offset
opcode  input  4  ALU operation code
sel1  input  1  1 = return ALU result, 0 = return memory read data
sel3  input  1  1 = ALU operand B is offset, 0 = operand2
w_r  input  1  1 = write memory in M stage
result2  output  DATA_WIDTH  result returned to CU
zero  output  1  ALU result of the M-stage op equals 0
addr_oob  output  1  sticky: an access used ALU result >= 2^ADDR_BITS

Behaviour:
- Reset (rst=0, async): all pipeline registers = 0; memory cleared to 0; result2=0, zero=0, addr_oob=0. An in-flight write is dropped. Released reset takes effect on the next rising edge.
- ALU (combinational), B = sel3 ? offset : operand2, result width DATA_WIDTH, carries discarded:
  - 0 ADD A+B; 1 SUB A-B (mod 2^W); 2 AND; 3 OR; 4 XOR; 5 NOT A
  - 6 SLL A<<B[2:0]; 7 SRL A>>B[2:0] (logical)
  - 8 SLTU (A<B)?1:0; 9 EQ (A==B)?1:0
  - 15 NOP: result 0, forces write enable off
  - 10-14 reserved: result 0, write enable off
- E stage (edge 1 after inputs valid): register alu_q, wdata_q=operand2, sel1_q, we_q=w_r & opcode legal.
- M stage (edge 2):
  - addr = alu_q[ADDR_BITS-1:0].
  - rdata_q <= mem[addr] (read-before-write: same-edge write to same address returns old data).
  - If we_q, mem[addr] <= wdata_q.
  - Register alu_q2=alu_q and sel1_q2=sel1_q.
  - If alu_q[DATA_WIDTH-1:ADDR_BITS] != 0 and the stage is a memory access (we_q or !sel1_q), set addr_oob; it stays set until reset. The access itself still uses the truncated address.
- result2 = sel1_q2 ? alu_q2 : rdata_q; zero = (alu_q2==0). Both are stable from 2 edges after inputs are sampled until the next M-stage update.
- Throughput: one op per cycle, fully pipelined, no stalls.
- The CU holds its inputs constant for ≥2 cycles per instruction, so the value it samples in WRITE_BACK is that instruction's result. Back-to-back different inputs each produce their own result 2 cycles later.
- Read-after-write to the same address from consecutive ops: a write issued at M edge k is visible to a read at M edge k+1 (no bypass needed).
- A CU held in RESET (opcode=15, all 0) produces result2=0 and no writes.

Decomposition:
- Package cu_dp_pkg:
  - DATA_WIDTH/ADDR_BITS defaults
  - opcode enum (OP_ADD..OP_EQ, OP_NOP=4'hF)
  - instruction-class constants (STD=2'b01, LOAD=2'b10, STORE=2'b11)
- Sub-module exec_alu: combinational ALU (A, B, opcode -> result, legal).
- exec_mem_unit instantiates exec_alu and holds the pipeline and memory.

Test Plan:
1. Reset, then opcode=0, operand1=5, operand2=7, sel3=0, sel1=1 held 2 cycles -> result2=12 on the 2nd edge after the inputs, zero=0.
2. Store: operand1=3, offset=4, opcode=ADD, sel3=1, w_r=1, operand2=8'hA5. Then load with same operands, w_r=0, sel1=0 -> result2=8'hA5 two edges after the load inputs; mem[7]=8'hA5.
3. Back-to-back: SUB 2-3 then EQ 9==9 on consecutive cycles -> result2=8'hFF then 8'h01 on consecutive cycles; zero=0 both.
4. Out of range: operand1=8'h30, offset=0, sel3=1, sel1=0 -> addr_oob=1 after M edge, reads mem[16]; addr_oob stays 1 after later legal ops.
5. Write then read same address on the next cycle (store 8'h3C to addr 2, then load addr 2) -> load returns 8'h3C. Simultaneous-edge case returns old data.
6. Assert rst=0 mid-cycle with a store in E stage -> outputs 0 immediately; after release, reading that address returns 0; opcode=15 with w_r=1 writes nothing.

Source files
------------

// File: rtl/cu_dp_pkg.sv
// Shared definitions for the control-unit / datapath interface:
// default widths, ALU opcode encoding and instruction-class codes.
package cu_dp_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_ADDR_BITS  = 5;

  typedef enum logic [3:0] {
    OP_ADD  = 4'h0,
    OP_SUB  = 4'h1,
    OP_AND  = 4'h2,
    OP_OR   = 4'h3,
    OP_XOR  = 4'h4,
    OP_NOT  = 4'h5,
    OP_SLL  = 4'h6,
    OP_SRL  = 4'h7,
    OP_SLTU = 4'h8,
    OP_EQ   = 4'h9,
    OP_NOP  = 4'hF
  } opcode_e;

  // Instruction classes as seen by the control unit.
  localparam logic [1:0] CLS_STD   = 2'b01;
  localparam logic [1:0] CLS_LOAD  = 2'b10;
  localparam logic [1:0] CLS_STORE = 2'b11;

  // Opcodes 0..9 do real work; NOP and the reserved codes never write memory.
  function automatic logic op_is_legal(input logic [3:0] op);
    return (op <= 4'h9);
  endfunction

endpackage

// File: rtl/exec_alu.sv
// Combinational ALU: result is truncated to W bits, carries are discarded.
// o_legal is low for NOP and reserved opcodes so the caller can gate writes.
module exec_alu
  import cu_dp_pkg::*;
#(
  parameter int W = DEF_DATA_WIDTH
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic [3:0]   i_opcode,
  output logic [W-1:0] o_result,
  output logic         o_legal
);

  logic [2:0] w_shamt;

  assign w_shamt = i_b[2:0];

  // Opcode decode; reserved codes and NOP produce 0.
  always_comb begin
    o_result = '0;
    o_legal  = op_is_legal(i_opcode);
    case (i_opcode)
      OP_ADD:  o_result = i_a + i_b;
      OP_SUB:  o_result = i_a - i_b;
      OP_AND:  o_result = i_a & i_b;
      OP_OR:   o_result = i_a | i_b;
      OP_XOR:  o_result = i_a ^ i_b;
      OP_NOT:  o_result = ~i_a;
      OP_SLL:  o_result = i_a << w_shamt;
      OP_SRL:  o_result = i_a >> w_shamt;
      OP_SLTU: o_result = (i_a < i_b) ? W'(1) : '0;
      OP_EQ:   o_result = (i_a == i_b) ? W'(1) : '0;
      default: o_result = '0;
    endcase
  end

endmodule

// File: rtl/exec_mem_unit.sv
// Execute / memory responder for the control unit.
// Two-stage pipeline: E registers the ALU result and store data, M performs
// the data-memory read (read-before-write) and optional write, then returns
// either the ALU result or the read data. One op per cycle, no stalls.
module exec_mem_unit
  import cu_dp_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_BITS  = DEF_ADDR_BITS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] operand1,
  input  logic [DATA_WIDTH-1:0] operand2,
  input  logic [DATA_WIDTH-1:0] offset,
  input  logic [3:0]            opcode,
  input  logic                  sel1,
  input  logic                  sel3,
  input  logic                  w_r,
  output logic [DATA_WIDTH-1:0] result2,
  output logic                  zero,
  output logic                  addr_oob
);

  localparam int DEPTH = 1 << ADDR_BITS;

  logic [DATA_WIDTH-1:0] w_alu_b;
  logic [DATA_WIDTH-1:0] w_alu_result;
  logic                  w_alu_legal;

  // E-stage registers
  logic [DATA_WIDTH-1:0] r_alu_q;
  logic [DATA_WIDTH-1:0] r_wdata_q;
  logic                  r_sel1_q;
  logic                  r_we_q;

  // M-stage registers
  logic [DATA_WIDTH-1:0] r_alu_q2;
  logic [DATA_WIDTH-1:0] r_rdata_q;
  logic                  r_sel1_q2;
  logic                  r_zero;
  logic                  r_addr_oob;

  // Data memory; cleared by reset, so it is built from flops.
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  logic [ADDR_BITS-1:0]  w_addr;
  logic                  w_addr_hi_set;
  logic                  w_mem_access;

  assign w_alu_b = sel3 ? offset : operand2;

  exec_alu #(
    .W(DATA_WIDTH)
  ) u_alu (
    .i_a      (operand1),
    .i_b      (w_alu_b),
    .i_opcode (opcode),
    .o_result (w_alu_result),
    .o_legal  (w_alu_legal)
  );

  // The access uses the truncated address; the upper bits only flag misuse.
  assign w_addr        = r_alu_q[ADDR_BITS-1:0];
  assign w_addr_hi_set = |r_alu_q[DATA_WIDTH-1:ADDR_BITS];
  assign w_mem_access  = r_we_q | ~r_sel1_q;

  // E stage: capture ALU result, store data and the gated write enable.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_alu_q   <= '0;
      r_wdata_q <= '0;
      r_sel1_q  <= 1'b0;
      r_we_q    <= 1'b0;
    end else begin
      r_alu_q   <= w_alu_result;
      r_wdata_q <= operand2;
      r_sel1_q  <= sel1;
      r_we_q    <= w_r & w_alu_legal;
    end
  end

  // M stage: read old data, forward ALU result, track sticky out-of-range flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_alu_q2   <= '0;
      r_rdata_q  <= '0;
      r_sel1_q2  <= 1'b0;
      r_zero     <= 1'b0;
      r_addr_oob <= 1'b0;
    end else begin
      r_alu_q2  <= r_alu_q;
      r_rdata_q <= r_mem[w_addr];
      r_sel1_q2 <= r_sel1_q;
      r_zero    <= (r_alu_q == '0);
      if (w_mem_access && w_addr_hi_set) begin
        r_addr_oob <= 1'b1;
      end
    end
  end

  // M stage memory write; an in-flight write is lost when reset hits.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (r_we_q) begin
      r_mem[w_addr] <= r_wdata_q;
    end
  end

  assign result2  = r_sel1_q2 ? r_alu_q2 : r_rdata_q;
  assign zero     = r_zero;
  assign addr_oob = r_addr_oob;

endmodule
